// File: rtl/ram_sched_pkg.sv
// Shared types for the RAM write scheduler: top-level state encoding and
// requester index constants used by the arbiter and the top level.
package ram_sched_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

endpackage

// File: rtl/ram_write_scheduler_if.sv
// Bus between the two write requesters and the scheduler, plus the registered
// write port that drives the register RAM.
interface ram_write_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  iClear;
  logic                  iReqA;
  logic [ADDR_WIDTH-1:0] iAddrA;
  logic [DATA_WIDTH-1:0] iDataA;
  logic                  iReqB;
  logic [ADDR_WIDTH-1:0] iAddrB;
  logic [DATA_WIDTH-1:0] iDataB;
  logic                  oAckA;
  logic                  oAckB;
  logic                  oWriteEnable;
  logic [ADDR_WIDTH-1:0] oWriteAddress;
  logic [DATA_WIDTH-1:0] oWriteData;
  logic                  oInitDone;

  modport master (
    output iClear, iReqA, iAddrA, iDataA, iReqB, iAddrB, iDataB,
    input  oAckA, oAckB, oWriteEnable, oWriteAddress, oWriteData, oInitDone
  );

  modport slave (
    input  iClear, iReqA, iAddrA, iDataA, iReqB, iAddrB, iDataB,
    output oAckA, oAckB, oWriteEnable, oWriteAddress, oWriteData, oInitDone
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: on a conflict the requester not granted last
// wins. The last-grant pointer resets to B so A wins the first conflict.
module rr_arbiter2
  import ram_sched_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       update_en
);
  logic last_reg;

  always_comb begin
    grant = '0;
    if (en) begin
      if (req[REQ_A] && (!req[REQ_B] || last_reg == 1'(REQ_B))) begin
        grant[REQ_A] = 1'b1;
      end else if (req[REQ_B]) begin
        grant[REQ_B] = 1'b1;
      end
    end
  end

  assign update_en = |grant;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      last_reg <= 1'(REQ_B);
    end else if (update_en) begin
      last_reg <= grant[REQ_B] ? 1'(REQ_B) : 1'(REQ_A);
    end
  end
endmodule

// File: rtl/ram_write_scheduler.sv
// Owns the RAM write port: zero-fills entries 0..MEM_SIZE after reset or on
// iClear, then issues round-robin writes from requesters A and B.
module ram_write_scheduler
  import ram_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_SIZE   = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  ram_write_scheduler_if.slave  bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  we_reg, we_next;
  logic                  ack_a_reg, ack_a_next;
  logic                  ack_b_reg, ack_b_next;
  logic                  done_reg, done_next;
  logic [1:0]            elig;
  logic [1:0]            grant;
  logic                  arb_en;
  logic                  upd_en;

  // A request still visible during its ack cycle has already been written.
  assign elig[REQ_A] = bus.iReqA && !ack_a_reg;
  assign elig[REQ_B] = bus.iReqB && !ack_b_reg;
  assign arb_en      = (state_reg == RUN) && !bus.iClear;

  rr_arbiter2 u_arb (
    .Clock     (Clock),
    .Reset     (Reset),
    .en        (arb_en),
    .req       (elig),
    .grant     (grant),
    .update_en (upd_en)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    we_next    = 1'b0;
    ack_a_next = 1'b0;
    ack_b_next = 1'b0;
    done_next  = done_reg;
    case (state_reg)
      CLEAR: begin
        we_next   = 1'b1;
        addr_next = cnt_reg;
        data_next = '0;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == LAST_ADDR) begin
          state_next = RUN;
          done_next  = 1'b1;
        end
      end
      RUN: begin
        if (bus.iClear) begin
          state_next = CLEAR;
          cnt_next   = '0;
          done_next  = 1'b0;
        end else if (upd_en) begin
          we_next = 1'b1;
          if (grant[REQ_A]) begin
            ack_a_next = 1'b1;
            addr_next  = bus.iAddrA;
            data_next  = bus.iDataA;
          end else begin
            ack_b_next = 1'b1;
            addr_next  = bus.iAddrB;
            data_next  = bus.iDataB;
          end
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      we_reg    <= 1'b0;
      ack_a_reg <= 1'b0;
      ack_b_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      we_reg    <= we_next;
      ack_a_reg <= ack_a_next;
      ack_b_reg <= ack_b_next;
      done_reg  <= done_next;
    end
  end

  assign bus.oWriteEnable  = we_reg;
  assign bus.oWriteAddress = addr_reg;
  assign bus.oWriteData    = data_reg;
  assign bus.oAckA         = ack_a_reg;
  assign bus.oAckB         = ack_b_reg;
  assign bus.oInitDone     = done_reg;
endmodule

// File: tb/tb_ram_write_scheduler.sv
// Randomized bench for ram_write_scheduler against a transaction-level model
// of the zero-fill sequence, round-robin issue order and resulting RAM image.
module tb_ram_write_scheduler;
  localparam int DW       = 16;
  localparam int AW       = 8;
  localparam int MEM_SIZE = 8;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  ram_write_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_write_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MEM_SIZE)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: fill progress, last winner, and the write issued by the last edge.
  bit            m_done;
  int            m_fill;
  int            m_last;
  bit            m_we, m_ack_a, m_ack_b;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] model_ram [256];
  logic [DW-1:0] tb_ram    [256];
  int            grant_log [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_done  = 1'b0;
    m_fill  = 0;
    m_last  = 1;
    m_we    = 1'b0;
    m_ack_a = 1'b0;
    m_ack_b = 1'b0;
    m_addr  = '0;
    m_data  = '0;
  endtask

  task automatic model_step();
    bit ea, eb;
    int winner;
    ea = bus.iReqA && !m_ack_a;
    eb = bus.iReqB && !m_ack_b;
    m_ack_a = 1'b0;
    m_ack_b = 1'b0;
    if (!m_done) begin
      m_we   = 1'b1;
      m_addr = AW'(m_fill);
      m_data = '0;
      if (m_fill == MEM_SIZE) m_done = 1'b1;
      else m_fill++;
    end else if (bus.iClear) begin
      m_done = 1'b0;
      m_fill = 0;
      m_we   = 1'b0;
    end else begin
      winner = -1;
      if (ea && eb) winner = 1 - m_last;
      else if (ea)  winner = 0;
      else if (eb)  winner = 1;
      m_we = (winner >= 0);
      if (winner == 0) begin
        m_ack_a = 1'b1; m_addr = bus.iAddrA; m_data = bus.iDataA; m_last = 0;
      end else if (winner == 1) begin
        m_ack_b = 1'b1; m_addr = bus.iAddrB; m_data = bus.iDataB; m_last = 1;
      end
    end
    if (m_we) model_ram[m_addr] = m_data;
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_we"},   32'(bus.oWriteEnable),  32'h0);
    check_val({tag, "_addr"}, 32'(bus.oWriteAddress), 32'h0);
    check_val({tag, "_data"}, 32'(bus.oWriteData),    32'h0);
    check_val({tag, "_acka"}, 32'(bus.oAckA),         32'h0);
    check_val({tag, "_ackb"}, 32'(bus.oAckB),         32'h0);
    check_val({tag, "_done"}, 32'(bus.oInitDone),     32'h0);
  endtask

  task automatic do_cycle();
    model_step();
    @(posedge Clock);
    #1;
    check_val("we",   32'(bus.oWriteEnable), 32'(m_we));
    check_val("acka", 32'(bus.oAckA),        32'(m_ack_a));
    check_val("ackb", 32'(bus.oAckB),        32'(m_ack_b));
    check_val("done", 32'(bus.oInitDone),    32'(m_done));
    if (m_we) begin
      check_val("addr", 32'(bus.oWriteAddress), 32'(m_addr));
      check_val("data", 32'(bus.oWriteData),    32'(m_data));
    end
    if (bus.oWriteEnable) tb_ram[bus.oWriteAddress] = bus.oWriteData;
    if (bus.oAckA) grant_log.push_back(0);
    if (bus.oAckB) grant_log.push_back(1);
    if (m_ack_a || m_ack_b)
      $display("write %s addr=%0d data=0x%04h", m_ack_a ? "A" : "B", m_addr, m_data);
  endtask

  task automatic async_reset(input string tag);
    #2 Reset = 1'b1;
    model_reset();
    #1 check_reset(tag);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  // Requester behaviour: hold until acked, then optionally move on to a new write.
  task automatic update_reqs();
    if (bus.iReqA && m_ack_a) bus.iReqA = 1'($urandom_range(0, 1));
    else if (!bus.iReqA)      bus.iReqA = ($urandom_range(0, 2) == 0);
    if (m_ack_a || !bus.iReqA) begin
      bus.iAddrA = AW'($urandom_range(0, 15));
      bus.iDataA = DW'($urandom);
    end
    if (bus.iReqB && m_ack_b) bus.iReqB = 1'($urandom_range(0, 1));
    else if (!bus.iReqB)      bus.iReqB = ($urandom_range(0, 2) == 0);
    if (m_ack_b || !bus.iReqB) begin
      bus.iAddrB = AW'($urandom_range(0, 15));
      bus.iDataB = DW'($urandom);
    end
    bus.iClear = ($urandom_range(0, 39) == 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      model_ram[i] = 'x;
      tb_ram[i]    = 'x;
    end
    bus.iClear = 1'b0;
    bus.iReqA  = 1'b0; bus.iAddrA = '0; bus.iDataA = '0;
    bus.iReqB  = 1'b0; bus.iAddrB = '0; bus.iDataB = '0;
    Reset = 1'b1;
    model_reset();
    #1 check_reset("por");
    @(negedge Clock);
    Reset = 1'b0;

    // Idle zero-fill, then a lone A write.
    repeat (12) do_cycle();
    bus.iReqA = 1'b1; bus.iAddrA = 8'd3; bus.iDataA = 16'h1234;
    do_cycle();
    bus.iReqA = 1'b0;
    do_cycle();
    check_val("ram_rd3", 32'(tb_ram[3]), 32'h1234);

    // Both requesters held through a fresh fill, then continuous contention.
    async_reset("rst2");
    bus.iReqA = 1'b1; bus.iAddrA = 8'd1; bus.iDataA = 16'hAAAA;
    bus.iReqB = 1'b1; bus.iAddrB = 8'd2; bus.iDataB = 16'hBBBB;
    grant_log.delete();
    repeat (17) do_cycle();
    check_val("seq_len", 32'(grant_log.size() >= 4), 32'h1);
    if (grant_log.size() >= 4) begin
      check_val("seq0", 32'(grant_log[0]), 32'd0);
      check_val("seq1", 32'(grant_log[1]), 32'd1);
      check_val("seq2", 32'(grant_log[2]), 32'd0);
      check_val("seq3", 32'(grant_log[3]), 32'd1);
    end

    // iClear while B requests, then reset five writes into the refill.
    bus.iReqA = 1'b0;
    bus.iClear = 1'b1;
    do_cycle();
    bus.iClear = 1'b0;
    repeat (5) do_cycle();
    async_reset("rst_mid");
    repeat (12) do_cycle();

    repeat (300) begin
      update_reqs();
      do_cycle();
    end
    bus.iReqA = 1'b0; bus.iReqB = 1'b0; bus.iClear = 1'b0;
    repeat (12) do_cycle();

    for (int i = 0; i < 16; i++)
      check_val($sformatf("ram[%0d]", i), 32'(tb_ram[i]), 32'(model_ram[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
